// File: rtl/ikbd_pkg.sv
// Shared constants and FSM state types for the IKBD serial link ACIA.
package ikbd_pkg;

  localparam int unsigned BIT_TICKS      = 16;
  localparam int unsigned START_MID_TICK = 8;

  typedef logic [3:0] tick_cnt_t;

  localparam tick_cnt_t BIT_LAST_TICK   = tick_cnt_t'(BIT_TICKS - 1);
  localparam tick_cnt_t START_LAST_TICK = tick_cnt_t'(START_MID_TICK - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

endpackage

// File: rtl/ikbd_acia_fifo.sv
// Receive FIFO for the IKBD ACIA; DEPTH must be a power of two >= 2.
module ikbd_acia_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + (AW+1)'(1);
    if (pop_i)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/ikbd_acia.sv
// 8N1 serial ACIA for the IKBD link with independent RX/TX tick dividers.
// Define IKBD_ACIA_RX_FIFO_EN to replace the single RX holding register with a FIFO.
module ikbd_acia
  import ikbd_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 16,
  parameter int unsigned RX_FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       rx_line,
  output logic       tx_line,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_overrun,
  output logic       rx_frame_err,
  input  logic       err_clr
);

  localparam int unsigned    DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || RX_FIFO_DEPTH < 2 ||
      (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_param_check
    $error("ikbd_acia: CLK_DIV must be >= 1 and RX_FIFO_DEPTH a power of two >= 2");
  end

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx_line;
      rx_sync_q <= rx_meta_q;
    end
  end

  logic [DIV_W-1:0] rx_div_q, rx_div_d;
  logic [DIV_W-1:0] tx_div_q, tx_div_d;
  logic             rx_tick, tx_tick, tx_accept;

  assign rx_tick   = (rx_div_q == DIV_LAST);
  assign tx_tick   = (tx_div_q == DIV_LAST);
  assign tx_accept = tx_valid && tx_ready;

  always_comb begin
    rx_div_d = rx_tick ? '0 : rx_div_q + DIV_W'(1);
    tx_div_d = (tx_accept || tx_tick) ? '0 : tx_div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_div_q <= '0;
      tx_div_q <= '0;
    end else begin
      rx_div_q <= rx_div_d;
      tx_div_q <= tx_div_d;
    end
  end

  rx_state_e rx_state_q, rx_state_d;
  tick_cnt_t rx_tcnt_q, rx_tcnt_d;
  logic [2:0] rx_bit_q, rx_bit_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic       rx_brk_q, rx_brk_d;
  logic       deliver_q;
  logic       stop_ok, stop_bad;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      rx_state_q <= RX_IDLE;
      rx_tcnt_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_brk_q   <= 1'b0;
      deliver_q  <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_tcnt_q  <= rx_tcnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_brk_q   <= rx_brk_d;
      deliver_q  <= stop_ok;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_tcnt_d  = rx_tcnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_brk_d   = rx_brk_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_tick && !rx_sync_q) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = '0;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (rx_tcnt_q == START_LAST_TICK) begin
            rx_tcnt_d  = '0;
            rx_bit_d   = '0;
            rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_d = rx_tcnt_q + tick_cnt_t'(1);
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          if (rx_tcnt_q == BIT_LAST_TICK) begin
            rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
            rx_tcnt_d  = '0;
            rx_bit_d   = rx_bit_q + 3'd1;
            if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          end else begin
            rx_tcnt_d = rx_tcnt_q + tick_cnt_t'(1);
          end
        end
      end
      RX_STOP: begin
        // After a bad stop bit, park here until the line idles high again.
        if (rx_brk_q) begin
          if (rx_sync_q) begin
            rx_brk_d   = 1'b0;
            rx_state_d = RX_IDLE;
          end
        end else if (stop_ok) begin
          rx_state_d = RX_IDLE;
        end else if (stop_bad) begin
          rx_brk_d = 1'b1;
        end else if (rx_tick) begin
          rx_tcnt_d = rx_tcnt_q + tick_cnt_t'(1);
        end
      end
    endcase
  end

  always_comb begin
    stop_ok  = 1'b0;
    stop_bad = 1'b0;
    if (rx_state_q == RX_STOP && !rx_brk_q && rx_tick && rx_tcnt_q == BIT_LAST_TICK) begin
      stop_ok  = rx_sync_q;
      stop_bad = !rx_sync_q;
    end
  end

  logic ovr_set;

`ifdef IKBD_ACIA_RX_FIFO_EN
  logic fifo_push, fifo_pop, fifo_empty, fifo_full;

  // A pop in the delivery cycle frees a slot, so a full FIFO still accepts.
  assign fifo_pop  = rx_valid && rx_ready;
  assign fifo_push = deliver_q && (!fifo_full || fifo_pop);
  assign ovr_set   = deliver_q && fifo_full && !fifo_pop;
  assign rx_valid  = !fifo_empty;

  ikbd_acia_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk     (clk),
    .res_n   (res_n),
    .push_i  (fifo_push),
    .wdata_i (rx_shift_q),
    .pop_i   (fifo_pop),
    .rdata_o (rx_data),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );
`else
  logic       hold_valid_q, hold_valid_d;
  logic [7:0] hold_data_q, hold_data_d;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    ovr_set      = 1'b0;
    if (hold_valid_q && rx_ready) hold_valid_d = 1'b0;
    if (deliver_q) begin
      if (!hold_valid_q || rx_ready) begin
        hold_valid_d = 1'b1;
        hold_data_d  = rx_shift_q;
      end else begin
        ovr_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign rx_valid = hold_valid_q;
  assign rx_data  = hold_data_q;
`endif

  logic overrun_q, overrun_d;
  logic ferr_q, ferr_d;

  always_comb begin
    overrun_d = ovr_set  ? 1'b1 : (err_clr ? 1'b0 : overrun_q);
    ferr_d    = stop_bad ? 1'b1 : (err_clr ? 1'b0 : ferr_q);
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_overrun   = overrun_q;
  assign rx_frame_err = ferr_q;

  tx_state_e  tx_state_q, tx_state_d;
  tick_cnt_t  tx_tcnt_q, tx_tcnt_d;
  logic [2:0] tx_bit_q, tx_bit_d;
  logic [7:0] tx_shift_q, tx_shift_d;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tx_state_q <= TX_IDLE;
      tx_tcnt_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_tcnt_q  <= tx_tcnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_accept) begin
          tx_state_d = TX_START;
          tx_tcnt_d  = '0;
          tx_shift_d = tx_data;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          if (tx_tcnt_q == BIT_LAST_TICK) begin
            tx_state_d = TX_DATA;
            tx_tcnt_d  = '0;
            tx_bit_d   = '0;
          end else begin
            tx_tcnt_d = tx_tcnt_q + tick_cnt_t'(1);
          end
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_tcnt_q == BIT_LAST_TICK) begin
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            tx_tcnt_d  = '0;
            tx_bit_d   = tx_bit_q + 3'd1;
            if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          end else begin
            tx_tcnt_d = tx_tcnt_q + tick_cnt_t'(1);
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          if (tx_tcnt_q == BIT_LAST_TICK) tx_state_d = TX_IDLE;
          else                            tx_tcnt_d  = tx_tcnt_q + tick_cnt_t'(1);
        end
      end
    endcase
  end

  always_comb begin
    tx_ready = 1'b0;
    tx_line  = 1'b1;
    unique case (tx_state_q)
      TX_IDLE:  tx_ready = 1'b1;
      TX_START: tx_line  = 1'b0;
      TX_DATA:  tx_line  = tx_shift_q[0];
      TX_STOP:  tx_line  = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_ikbd_acia.sv
// Self-checking bench for ikbd_acia: RX vector table, TX waveform, overrun,
// glitch, randomized concurrent traffic and mid-frame reset.
`timescale 1ns/1ps
module tb_ikbd_acia;

  localparam int unsigned CLK_DIV  = 16;
  localparam int unsigned BIT_CLKS = 16 * CLK_DIV;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       rx_line = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = '0;
  logic       err_clr = 1'b0;
  logic       ready_mode = 1'b0;
  logic       ready_manual = 1'b0;
  logic       rand_bit = 1'b0;
  logic       rx_ready;
  logic       tx_line, tx_ready, rx_valid, rx_overrun, rx_frame_err;
  logic [7:0] rx_data;

  int checks = 0;
  int fails  = 0;
  logic [7:0] got[$];
  logic [7:0] expq[$];

  assign rx_ready = ready_mode ? rand_bit : ready_manual;

  ikbd_acia #(.CLK_DIV(CLK_DIV), .RX_FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .res_n        (res_n),
    .rx_line      (rx_line),
    .tx_line      (tx_line),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_overrun   (rx_overrun),
    .rx_frame_err (rx_frame_err),
    .err_clr      (err_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rand_bit = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    if (res_n && rx_valid && rx_ready) got.push_back(rx_data);
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] got_at(input int i);
    if (i < got.size()) return got[i];
    return 8'hxx;
  endfunction

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line = fr[i];
      tick(BIT_CLKS);
    end
    rx_line = 1'b1;
    tick(32);
  endtask

  task automatic wait_tx_ready(input string name);
    int n;
    n = 0;
    while (tx_ready !== 1'b1 && n < 4000) begin
      tick(1);
      n++;
    end
    check(name, tx_ready, 1);
  endtask

  task automatic send_tx_check(input logic [7:0] d, input string name);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    wait_tx_ready({name, "_rdy"});
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    tick(BIT_CLKS / 2);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("%s_bit%0d", name, k), tx_line, fr[k]);
      if (k < 9) tick(BIT_CLKS);
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_cnt;
    logic       exp_ferr;
  } rx_vec_t;

  rx_vec_t vecs[5];

  initial begin
    logic [9:0] fr12;
    int         match;
    logic [7:0] drx, dtx;

    vecs[0] = '{8'h80, 1'b1, 1, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 1, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 1, 1'b0};
    vecs[3] = '{8'hA5, 1'b1, 1, 1'b0};
    vecs[4] = '{8'h55, 1'b0, 0, 1'b1};

    tick(3);
    check("rst_tx_line", tx_line, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_overrun", rx_overrun, 0);
    check("rst_ferr", rx_frame_err, 0);
    res_n = 1'b1;
    ready_manual = 1'b1;
    tick(4);

    for (int i = 0; i < 5; i++) begin
      got.delete();
      send_rx(vecs[i].data, vecs[i].stop);
      tick(8);
      check($sformatf("vec%0d_count", i), got.size(), vecs[i].exp_cnt);
      if (vecs[i].exp_cnt > 0) check($sformatf("vec%0d_data", i), got_at(0), vecs[i].data);
      check($sformatf("vec%0d_ferr", i), rx_frame_err, vecs[i].exp_ferr);
      check($sformatf("vec%0d_ovr", i), rx_overrun, 0);
      check($sformatf("vec%0d_valid_idle", i), rx_valid, 0);
      if (vecs[i].exp_ferr) begin
        pulse_clr();
        check($sformatf("vec%0d_ferr_clr", i), rx_frame_err, 0);
      end
    end

    wait_tx_ready("tx12_rdy");
    tx_data  = 8'h12;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    fr12 = {1'b1, 8'h12, 1'b0};
    for (int k = 0; k < 10; k++) begin
      match = 0;
      for (int j = 0; j < int'(BIT_CLKS); j++) begin
        if (tx_line === fr12[k] && tx_ready === 1'b0) match++;
        tick(1);
      end
      check($sformatf("tx12_bit%0d_clks", k), match, BIT_CLKS);
    end
    check("tx12_ready_back", tx_ready, 1);
    check("tx12_idle_line", tx_line, 1);

    got.delete();
    rx_line = 1'b0;
    tick(64);
    rx_line = 1'b1;
    tick(BIT_CLKS * 11);
    check("glitch_count", got.size(), 0);
    check("glitch_valid", rx_valid, 0);
    check("glitch_ferr", rx_frame_err, 0);
    send_rx(8'h3C, 1'b1);
    tick(8);
    check("post_glitch_count", got.size(), 1);
    check("post_glitch_data", got_at(0), 8'h3C);

    got.delete();
    ready_manual = 1'b0;
    tick(2);
    send_rx(8'hF8, 1'b1);
    send_rx(8'h01, 1'b1);
    tick(8);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data_first", rx_data, 8'hF8);
`ifdef IKBD_ACIA_RX_FIFO_EN
    check("ovr_flag", rx_overrun, 0);
`else
    check("ovr_flag", rx_overrun, 1);
`endif
    ready_manual = 1'b1;
    tick(1);
    ready_manual = 1'b0;
    tick(2);
`ifdef IKBD_ACIA_RX_FIFO_EN
    check("ovr_valid_second", rx_valid, 1);
    check("ovr_data_second", rx_data, 8'h01);
    ready_manual = 1'b1;
    tick(1);
    ready_manual = 1'b0;
    tick(2);
    check("ovr_read_count", got.size(), 2);
    check("ovr_read0", got_at(0), 8'hF8);
    check("ovr_read1", got_at(1), 8'h01);
`else
    check("ovr_valid_after_read", rx_valid, 0);
    check("ovr_read_count", got.size(), 1);
    check("ovr_read0", got_at(0), 8'hF8);
`endif
    pulse_clr();
    check("ovr_clr", rx_overrun, 0);

    got.delete();
    expq.delete();
    ready_mode = 1'b1;
    for (int it = 0; it < 4; it++) begin
      drx = 8'($urandom);
      dtx = 8'($urandom);
      expq.push_back(drx);
      fork
        send_rx(drx, 1'b1);
        send_tx_check(dtx, $sformatf("rand%0d_tx", it));
      join
    end
    tick(40);
    ready_mode   = 1'b0;
    ready_manual = 1'b1;
    tick(4);
    check("rand_rx_count", got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check($sformatf("rand_rx%0d", i), got_at(i), expq[i]);
    check("rand_ovr", rx_overrun, 0);
    check("rand_ferr", rx_frame_err, 0);

    got.delete();
    fork
      send_rx(8'hC3, 1'b1);
      begin
        wait_tx_ready("rst_tx_rdy");
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(4 * BIT_CLKS + 100);
        check("rst_mid_pre_line", tx_line, 0);
        @(negedge clk);
        res_n = 1'b0;
        #1;
        check("rst_mid_tx_line", tx_line, 1);
        check("rst_mid_tx_ready", tx_ready, 1);
        check("rst_mid_rx_valid", rx_valid, 0);
        check("rst_mid_rx_data", rx_data, 8'h00);
      end
    join
    @(negedge clk);
    res_n = 1'b1;
    tick(BIT_CLKS * 2);
    check("rst_mid_no_byte", got.size(), 0);
    check("rst_mid_valid_after", rx_valid, 0);
    send_rx(8'h81, 1'b1);
    tick(8);
    check("rst_after_count", got.size(), 1);
    check("rst_after_data", got_at(0), 8'h81);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ikbd_acia.md
IKBD_ACIA -- requirements
Module: ikbd_acia

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clk cycles per 16x oversample tick (2 MHz / 16 / 16 = 7812.5 baud).
REQ-002 SHALL have parameter RX_FIFO_DEPTH, default 4: receive FIFO entries, used only when IKBD_ACIA_RX_FIFO_EN is defined; power of two.
REQ-003 SHALL have ports:
- clk  in  1  single system clock.
- res_n  in  1  reset; asynchronous assert, active-low.
- rx_line  in  1  serial input driven by the ikbd tx pin.
- tx_line  out  1  serial output to the ikbd rx pin.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  transmitter accepts a byte.
- rx_data  out  8  received byte.
- rx_valid  out  1  rx_data valid.
- rx_ready  in  1  consumer accepts rx_data.
- rx_overrun  out  1  sticky: a byte was dropped.
- rx_frame_err  out  1  sticky: stop bit sampled low.
- err_clr  in  1  clears both sticky flags.

Function
REQ-004 SHALL pass rx_line through a 2-flop synchronizer whose flops reset to 1.
REQ-005 SHALL use independent rx and tx tick dividers; the tx divider restarts on byte accept.
REQ-006 Frame format SHALL be 8N1, LSB first, 16 ticks per bit.
REQ-007 RX FSM SHALL use states IDLE, START, DATA, STOP.
- IDLE->START on a low synchronized sample at a tick.
- START: at tick 8, low goes to DATA; high goes back to IDLE (glitch reject).
- DATA: sample every 16 ticks, 8 bits.
- STOP: sample after 16 ticks.
REQ-008 STOP sampled high SHALL deliver the byte to the holding stage one clk later.
REQ-009 STOP sampled low SHALL set rx_frame_err, discard the byte, and hold the FSM until rx_line is high before IDLE.
REQ-010 Handshake SHALL transfer on rx_valid && rx_ready; rx_valid and rx_data stay stable until then.
REQ-011 Delivery into a full holding stage SHALL set rx_overrun, drop the new byte and keep the stored data.
REQ-012 Delivery in the same cycle as a consumer accept SHALL NOT set rx_overrun; the new byte is stored.
REQ-013 TX FSM SHALL use states IDLE, START, DATA, STOP; tx_ready is high only in IDLE.
REQ-014 Accept on tx_valid && tx_ready SHALL drive tx_line low on the next clk.
REQ-015 Each TX bit SHALL last exactly 16*CLK_DIV clk; the full frame is 160*CLK_DIV clk.
REQ-016 tx_ready SHALL reassert on the clk after the stop bit ends; back-to-back frames have no extra idle.
REQ-017 err_clr SHALL clear both sticky flags; a set event in the same cycle wins.
REQ-018 RX and TX SHALL operate fully concurrently.

Reset
REQ-019 While res_n is low SHALL force: tx_line=1, tx_ready=1, rx_valid=0, rx_data=0x00, rx_overrun=0, rx_frame_err=0, both FSMs IDLE, dividers 0, FIFO empty.
REQ-020 Reset mid-frame SHALL abort both directions immediately, with no partial byte delivered.

Configuration
REQ-021 With IKBD_ACIA_RX_FIFO_EN defined, the holding stage SHALL be an RX_FIFO_DEPTH-entry FIFO; overrun occurs only when it is full.
REQ-022 Without IKBD_ACIA_RX_FIFO_EN, the holding stage SHALL be a single register.

Structure
REQ-023 Package ikbd_pkg SHALL hold the RX/TX FSM state enum typedefs, BIT_TICKS=16 and the start-bit mid-sample constant 8.
REQ-024 Sub-module ikbd_acia_fifo SHALL implement the optional FIFO.

Verification
REQ-025 RX 0x80, rx_ready=1 -> rx_valid pulses with rx_data=0x80; flags 0.
REQ-026 tx_data=0x12 accepted -> tx_line sequence 0,0,1,0,0,1,0,0,0,1 at 256 clk per bit; tx_ready low 2560 clk.
REQ-027 rx_line low for 64 clk (1/4 bit), then high -> no rx_valid, FSM back to IDLE.
REQ-028 RX 0x55 with stop bit 0 -> rx_frame_err=1, no rx_valid; err_clr -> flag 0.
REQ-029 RX 0xF8 then 0x01 with rx_ready=0 and no FIFO -> rx_data=0xF8, rx_overrun=1; with FIFO, both bytes read in order, overrun 0.
REQ-030 res_n low at bit 4 of a TX frame -> tx_line=1 and tx_ready=1 with no clk edge.
